writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Y86-64 SEQ write-back stage: owns the architectural register file and commits valE/valM results at the end of each instruction cycle.
- It is the write side of the register interface that decode reads. It drives r0..r14 directly into decode, so those values are the decode stage's register inputs.
- It also tracks processor status (AOK/HLT/ADR/INS), blocks all writes once the processor stops, and counts retired instructions.

Parameters:
- RSP_RESET, 64'd0, reset value of r4 (%rsp); all other registers reset to 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, active-high, synchronous.
- wb_valid  in  1  a valid instruction is completing this cycle; no update when 0.
- icode  in  4  instruction code from fetch.
- rA  in  4  register A specifier; 4'hF means none.
- rB  in  4  register B specifier; 4'hF means none.
- cnd  in  1  condition result from execute; used only by icode 2.
- valE  in  64  ALU result.
- valM  in  64  value read from data memory.
- imem_error  in  1  fetch address invalid (fetch's in_mem).
- instr_invalid  in  1  illegal icode/ifun (fetch's in_inst).
- dmem_error  in  1  data-memory address invalid.
- r0..r14  out  64 each, signed  architectural registers (15 output ports).
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  high whenever stat != AOK.
- retired  out  CNT_W  number of instructions retired.

Behaviour:
- Reset (rst=1 at a rising edge):
  - r0..r14 cleared to 0, except r4 = RSP_RESET.
  - stat=AOK, halted=0, retired=0.
  - rst overrides wb_valid in the same cycle and may be asserted in any state.
- Destination selection (combinational, from icode/rA/rB/cnd). Register ID F means no write.
  - icode 2 (rrmovq/cmovXX): dstE = rB if cnd=1, else F.
  - icode 3 (irmovq) and 6 (OPq): dstE = rB.
  - icode 8 (call), 9 (ret), A (pushq): dstE = 4.
  - icode B (popq): dstE = 4 and dstM = rA.
  - icode 5 (mrmovq): dstM = rA.
  - All other icodes: both dstE and dstM are F.
- Next-status evaluation, only when wb_valid=1 and stat=AOK, in this priority order:
  - imem_error → ADR.
  - instr_invalid → INS.
  - dmem_error → ADR.
  - icode 0 → HLT.
  - otherwise AOK.
- Commit on a rising edge with wb_valid=1, stat=AOK and next status AOK:
  - write valE to dstE and valM to dstM;
  - retired increments by 1 and wraps modulo 2^CNT_W.
- Write port collision: if dstE == dstM (e.g. popq %rsp), valM wins and valE is discarded.
- Faulting or halting instruction (next status != AOK):
  - no register writes;
  - stat takes the new code and halted=1 on the same edge;
  - retired increments only for HLT, not for ADR or INS.
- Stopped state is sticky: once stat != AOK, all inputs are ignored until rst.
- Latency and visibility:
  - a write becomes visible on r0..r14 right after the committing edge;
  - r0..r14 are plain registers with no write-through bypass, so decode in the same cycle sees the old values.
- wb_valid=0: all state holds.
- The 64-bit values are stored unchanged; no sign or width conversion.

Test Plan:
- Reset with RSP_RESET=64'h200, then irmovq $10,%rbx (icode 3, rB=3, valE=10) → r3=10, r4=0x200, retired=1, stat=1.
- OPq with rB=2, valE=-5 → r2=-5 (signed). Then cmovXX with cnd=0, rB=2, valE=7 → r2 stays -5. Same with cnd=1 → r2=7.
- popq %rsp (icode B, rA=4, valE=0x208, valM=0x55) → r4=0x55 (valM wins). popq %rax with rA=0, same values → r0=0x55, r4=0x208.
- Halt (icode 0) → stat=2, halted=1, retired incremented. A following irmovq $1,%rcx → r1 unchanged, retired unchanged.
- Fault priority: imem_error=1 together with instr_invalid=1 → stat=3, no writes, retired unchanged. From reset, instr_invalid alone → stat=4.
- Reset in the middle: after HLT, assert rst together with wb_valid=1 and an irmovq → all registers 0 (r4=RSP_RESET), stat=1, retired=0. The next irmovq commits normally.

Source files
------------

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage.
// Owns the architectural register file (r0..r14), tracks processor status
// and counts retired instructions. Once the processor stops, every input
// is ignored until reset.
module writeback_regfile #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = 64'd0,
  parameter int                CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [3:0]               icode,
  input  logic [3:0]               rA,
  input  logic [3:0]               rB,
  input  logic                     cnd,
  input  logic signed [DATA_W-1:0] valE,
  input  logic signed [DATA_W-1:0] valM,
  input  logic                     imem_error,
  input  logic                     instr_invalid,
  input  logic                     dmem_error,
  output logic signed [DATA_W-1:0] r0,
  output logic signed [DATA_W-1:0] r1,
  output logic signed [DATA_W-1:0] r2,
  output logic signed [DATA_W-1:0] r3,
  output logic signed [DATA_W-1:0] r4,
  output logic signed [DATA_W-1:0] r5,
  output logic signed [DATA_W-1:0] r6,
  output logic signed [DATA_W-1:0] r7,
  output logic signed [DATA_W-1:0] r8,
  output logic signed [DATA_W-1:0] r9,
  output logic signed [DATA_W-1:0] r10,
  output logic signed [DATA_W-1:0] r11,
  output logic signed [DATA_W-1:0] r12,
  output logic signed [DATA_W-1:0] r13,
  output logic signed [DATA_W-1:0] r14,
  output logic [2:0]               stat,
  output logic                     halted,
  output logic [CNT_W-1:0]         retired
);

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic signed [DATA_W-1:0] regs [15];
  stat_e                    stat_q;
  stat_e                    stat_next;
  logic [CNT_W-1:0]         retired_q;
  logic [3:0]               dst_e;
  logic [3:0]               dst_m;
  logic                     active;
  logic                     commit;

  // Fault priority: fetch address error beats illegal instruction, which
  // beats a data-memory error; halt only matters if nothing faulted.
  function automatic stat_e next_status(input logic       ie,
                                        input logic       ii,
                                        input logic       de,
                                        input logic [3:0] ic);
    stat_e s;
    if (ie)                s = STAT_ADR;
    else if (ii)           s = STAT_INS;
    else if (de)           s = STAT_ADR;
    else if (ic == I_HALT) s = STAT_HLT;
    else                   s = STAT_AOK;
    return s;
  endfunction

  // Destination register selection from the instruction fields
  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (icode)
      I_CMOV:          dst_e = cnd ? rB : REG_NONE;
      I_IRMOVQ, I_OPQ: dst_e = rB;
      I_CALL, I_RET,
      I_PUSHQ:         dst_e = REG_RSP;
      I_POPQ: begin
        dst_e = REG_RSP;
        dst_m = rA;
      end
      I_MRMOVQ:        dst_m = rA;
      default: begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
      end
    endcase
  end

  assign stat_next = next_status(imem_error, instr_invalid, dmem_error, icode);
  assign active    = wb_valid && (stat_q == STAT_AOK);
  assign commit    = active && (stat_next == STAT_AOK);

  // Register file: valM is written after valE so it wins a dstE==dstM clash
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? $signed(RSP_RESET) : '0;
      end
    end else if (commit) begin
      if (dst_e != REG_NONE) regs[dst_e] <= valE;
      if (dst_m != REG_NONE) regs[dst_m] <= valM;
    end
  end

  // Status and retired counter; a stopped processor stays stopped until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else if (active) begin
      stat_q <= stat_next;
      if (stat_next == STAT_AOK || stat_next == STAT_HLT) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign stat    = stat_q;
  assign halted  = (stat_q != STAT_AOK);
  assign retired = retired_q;

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: a driver issues one instruction
// per cycle and queues the architectural state expected after that edge;
// a monitor on the falling edge compares the DUT state against the queue.
module tb_writeback_regfile;

  localparam logic [63:0] RSP_INIT = 64'h200;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        imem_error;
  logic        instr_invalid;
  logic        dmem_error;
  logic signed [63:0] dut_r [15];
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] retired;

  writeback_regfile #(
    .DATA_W   (64),
    .RSP_RESET(RSP_INIT),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .icode        (icode),
    .rA           (rA),
    .rB           (rB),
    .cnd          (cnd),
    .valE         (valE),
    .valM         (valM),
    .imem_error   (imem_error),
    .instr_invalid(instr_invalid),
    .dmem_error   (dmem_error),
    .r0           (dut_r[0]),
    .r1           (dut_r[1]),
    .r2           (dut_r[2]),
    .r3           (dut_r[3]),
    .r4           (dut_r[4]),
    .r5           (dut_r[5]),
    .r6           (dut_r[6]),
    .r7           (dut_r[7]),
    .r8           (dut_r[8]),
    .r9           (dut_r[9]),
    .r10          (dut_r[10]),
    .r11          (dut_r[11]),
    .r12          (dut_r[12]),
    .r13          (dut_r[13]),
    .r14          (dut_r[14]),
    .stat         (stat),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [14:0][63:0] r;
    logic [2:0]        st;
    logic [31:0]       ret;
    logic [31:0]       cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural state as plain arrays
  logic [14:0][63:0] m_reg;
  logic [2:0]        m_stat;
  logic [31:0]       m_ret;

  function automatic void model_step(input logic r, input logic v, input logic [3:0] ic,
                                     input logic [3:0] a, input logic [3:0] b, input logic c,
                                     input logic [63:0] e, input logic [63:0] m,
                                     input logic ie, input logic ii, input logic de);
    logic [2:0] ns;
    int de_id;
    int dm_id;
    if (r) begin
      m_reg    = '0;
      m_reg[4] = RSP_INIT;
      m_stat   = 3'd1;
      m_ret    = 32'd0;
      return;
    end
    if (!v || m_stat != 3'd1) return;
    if (ie)            ns = 3'd3;
    else if (ii)       ns = 3'd4;
    else if (de)       ns = 3'd3;
    else if (ic == 0)  ns = 3'd2;
    else               ns = 3'd1;
    if (ns != 3'd1) begin
      m_stat = ns;
      if (ns == 3'd2) m_ret = m_ret + 1;
      return;
    end
    de_id = 15;
    dm_id = 15;
    if (ic == 4'h2 && c)                de_id = int'(b);
    if (ic == 4'h3 || ic == 4'h6)       de_id = int'(b);
    if (ic >= 4'h8 && ic <= 4'hB)       de_id = 4;
    if (ic == 4'hB || ic == 4'h5)       dm_id = int'(a);
    if (de_id != 15) m_reg[de_id] = e;
    if (dm_id != 15) m_reg[dm_id] = m;
    m_ret = m_ret + 1;
  endfunction

  task automatic issue(input logic r, input logic v, input logic [3:0] ic,
                       input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [63:0] e, input logic [63:0] m,
                       input logic ie, input logic ii, input logic de);
    exp_t x;
    rst = r; wb_valid = v; icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; imem_error = ie; instr_invalid = ii; dmem_error = de;
    model_step(r, v, ic, a, b, c, e, m, ie, ii, de);
    x.r   = m_reg;
    x.st  = m_stat;
    x.ret = m_ret;
    x.cyc = 32'(cyc + 1);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compare the state the DUT presents after each issued edge
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc == 32'(cyc)) begin
      exp_t x;
      x = q.pop_front();
      for (int i = 0; i < 15; i++) begin
        check($sformatf("r%0d", i), dut_r[i], x.r[i]);
      end
      check("stat", 64'(stat), 64'(x.st));
      check("halted", 64'(halted), 64'(x.st != 3'd1));
      check("retired", 64'(retired), 64'(x.ret));
    end
  end

  localparam logic [3:0] NO = 4'hF;

  initial begin
    rst = 1'b1; wb_valid = 1'b0; icode = '0; rA = NO; rB = NO; cnd = 1'b0;
    valE = '0; valM = '0; imem_error = 1'b0; instr_invalid = 1'b0; dmem_error = 1'b0;
    m_reg = '0; m_stat = 3'd1; m_ret = '0;
    @(posedge clk);
    #1;

    // Directed sequence
    issue(1, 0, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);                   // reset
    issue(0, 1, 4'h3, NO, 4'd3, 0, 64'd10, 0, 0, 0, 0);            // irmovq $10,%rbx
    issue(0, 1, 4'h6, NO, 4'd2, 0, -64'sd5, 0, 0, 0, 0);           // OPq -> r2=-5
    issue(0, 1, 4'h2, NO, 4'd2, 0, 64'd7, 0, 0, 0, 0);             // cmov not taken
    issue(0, 1, 4'h2, NO, 4'd2, 1, 64'd7, 0, 0, 0, 0);             // cmov taken
    issue(0, 0, 4'h3, NO, 4'd5, 0, 64'd99, 0, 0, 0, 0);            // wb_valid=0 holds
    issue(0, 1, 4'hB, 4'd4, NO, 0, 64'h208, 64'h55, 0, 0, 0);      // popq %rsp
    issue(0, 1, 4'hB, 4'd0, NO, 0, 64'h208, 64'h55, 0, 0, 0);      // popq %rax
    issue(0, 1, 4'h5, 4'd14, NO, 0, 0, 64'h8000_0000_0000_0001, 0, 0, 0); // mrmovq
    issue(0, 1, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);                   // halt
    issue(0, 1, 4'h3, NO, 4'd1, 0, 64'd1, 0, 0, 0, 0);             // ignored
    issue(1, 0, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 4'h3, NO, 4'd5, 0, 64'd3, 0, 1, 1, 0);             // ADR beats INS
    issue(0, 1, 4'h3, NO, 4'd5, 0, 64'd3, 0, 0, 0, 0);             // sticky
    issue(1, 0, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 4'h3, NO, 4'd6, 0, 64'd4, 0, 0, 1, 0);             // INS
    issue(1, 0, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 4'hA, NO, NO, 0, 64'h1F8, 0, 0, 0, 1);             // dmem ADR
    issue(1, 0, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 4'h3, NO, 4'd7, 0, 64'd11, 0, 0, 0, 0);
    issue(0, 1, 4'h0, NO, NO, 0, 0, 0, 0, 0, 0);                   // halt
    issue(1, 1, 4'h3, NO, 4'd7, 0, 64'd12, 0, 0, 0, 0);            // rst wins
    issue(0, 1, 4'h3, NO, 4'd7, 0, 64'd13, 0, 0, 0, 0);            // commits

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic [3:0] ic;
      r  = ((m_stat != 3'd1) && ($urandom % 3 == 0)) || ($urandom % 60 == 0);
      ic = ($urandom % 10 == 0) ? 4'h0 : 4'($urandom_range(1, 11));
      issue(r, ($urandom % 4) != 0, ic, 4'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom % 25) == 0, ($urandom % 25) == 0, ($urandom % 25) == 0);
    end

    wb_valid = 1'b0;
    rst      = 1'b0;
    for (int k = 0; k < 5 && q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
